// File: rtl/riscv_core_div_pkg.sv
// rtl/riscv_core_div_pkg.sv - shared state, op encodings and counter width for riscv_core_div
package riscv_core_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

  // funct3[1:0] of the M-extension divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int CNT_W = 7;

endpackage

// File: rtl/riscv_core_div_step.sv
// rtl/riscv_core_div_step.sv - one restoring-division iteration: shift, trial subtract, select
module riscv_core_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem < divisor on entry, so the shifted value fits W+1 bits and diff[W] is the borrow
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_core_div.sv
// rtl/riscv_core_div.sv - iterative radix-2 RV64M divider: FSM, counter, sign flags, result register
module riscv_core_div
  import riscv_core_div_pkg::*;
#(
  parameter int W_DIV_XLEN = 64
) (
  input  logic                  i_div_clk,
  input  logic                  i_div_rst,
  input  logic                  i_div_start,
  input  logic [1:0]            i_div_op,
  input  logic                  i_div_word,
  input  logic [W_DIV_XLEN-1:0] i_div_rs1,
  input  logic [W_DIV_XLEN-1:0] i_div_rs2,
  input  logic                  i_div_flush,
  output logic [W_DIV_XLEN-1:0] o_div_result,
  output logic                  o_div_valid,
  output logic                  o_div_busy
);

  localparam int XL = W_DIV_XLEN;
  localparam int HL = W_DIV_XLEN / 2;
  localparam logic [XL-1:0] MIN_XL = {1'b1, {(XL-1){1'b0}}};
  localparam logic [HL-1:0] MIN_HL = {1'b1, {(HL-1){1'b0}}};

  div_state_e       state;
  logic [1:0]       op_q;
  logic             word_q;
  logic [XL-1:0]    a_q;
  logic [XL-1:0]    b_q;
  logic [XL-1:0]    rem_q;
  logic [XL-1:0]    quo_q;
  logic [XL-1:0]    dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             accept;
  logic             in_signed;
  logic [XL-1:0]    a_in;
  logic [XL-1:0]    b_in;
  logic             op_signed;
  logic             op_rem;
  logic             a_neg;
  logic             b_neg;
  logic [XL-1:0]    a_abs;
  logic [XL-1:0]    b_abs;
  logic             div_zero;
  logic             sgn_ovf;
  logic [XL-1:0]    spec_raw;
  logic [XL-1:0]    spec_res;
  logic [XL-1:0]    quo_fix;
  logic [XL-1:0]    rem_fix;
  logic [XL-1:0]    fix_res;
  logic [XL-1:0]    rem_nxt;
  logic [XL-1:0]    quo_nxt;

  // W ops keep the low half and extend it; sx selects sign- vs zero-extension
  function automatic logic [XL-1:0] word_ext(input logic [XL-1:0] v, input logic w,
                                             input logic sx);
    if (w) return {{HL{sx & v[HL-1]}}, v[HL-1:0]};
    return v;
  endfunction

  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && i_div_start && !i_div_flush;

  assign o_div_busy = !i_div_rst &&
                      ((state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX) || accept);

  always_comb begin
    in_signed = (i_div_op == OP_DIV) || (i_div_op == OP_REM);
    a_in      = word_ext(i_div_rs1, i_div_word, in_signed);
    b_in      = word_ext(i_div_rs2, i_div_word, in_signed);

    op_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    op_rem    = (op_q == OP_REM) || (op_q == OP_REMU);
    a_neg     = op_signed & a_q[XL-1];
    b_neg     = op_signed & b_q[XL-1];
    a_abs     = a_neg ? -a_q : a_q;
    b_abs     = b_neg ? -b_q : b_q;

    div_zero  = (b_q == '0);
    sgn_ovf   = op_signed &&
                (word_q ? ((a_q[HL-1:0] == MIN_HL) && (b_q[HL-1:0] == '1))
                        : ((a_q == MIN_XL) && (b_q == '1)));
    if (div_zero) spec_raw = op_rem ? a_q : '1;
    else          spec_raw = op_rem ? '0 : a_q;
    spec_res  = word_ext(spec_raw, word_q, 1'b1);

    quo_fix   = q_neg_q ? -quo_q : quo_q;
    rem_fix   = r_neg_q ? -rem_q : rem_q;
    fix_res   = word_ext(op_rem ? rem_fix : quo_fix, word_q, 1'b1);
  end

  riscv_core_div_step #(
    .W (XL)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge i_div_clk) begin
    if (i_div_rst) begin
      state        <= ST_IDLE;
      o_div_result <= '0;
      o_div_valid  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      o_div_valid <= 1'b0;
      if (i_div_flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (i_div_start) begin
              state  <= ST_PREP;
              op_q   <= i_div_op;
              word_q <= i_div_word;
              a_q    <= a_in;
              b_q    <= b_in;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_PREP: begin
            if (div_zero || sgn_ovf) begin
              o_div_result <= spec_res;
              o_div_valid  <= 1'b1;
              state        <= ST_DONE;
            end else begin
              // W dividends sit in the upper half so the first HL shifts consume them
              rem_q   <= '0;
              quo_q   <= word_q ? (a_abs << HL) : a_abs;
              dvs_q   <= b_abs;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              cnt_q   <= word_q ? CNT_W'(HL) : CNT_W'(XL);
              state   <= ST_CALC;
            end
          end
          ST_CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state <= ST_FIX;
          end
          ST_FIX: begin
            o_div_result <= fix_res;
            o_div_valid  <= 1'b1;
            state        <= ST_DONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_div.sv
// tb/tb_riscv_core_div.sv - scoreboard testbench for riscv_core_div
module tb_riscv_core_div;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        flush;
  logic [63:0] result;
  logic        valid;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'd0;

  always #5 clk = ~clk;

  riscv_core_div #(
    .W_DIV_XLEN (64)
  ) dut (
    .i_div_clk    (clk),
    .i_div_rst    (rst),
    .i_div_start  (start),
    .i_div_op     (op),
    .i_div_word   (word),
    .i_div_rs1    (rs1),
    .i_div_rs2    (rs2),
    .i_div_flush  (flush),
    .o_div_result (result),
    .o_div_valid  (valid),
    .o_div_busy   (busy)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] r;
    logic        sgn;
    sgn = !o[0];
    x = a;
    y = b;
    if (w) begin
      x = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      y = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end
    if (y == 64'd0) r = o[1] ? x : '1;
    else if (sgn && (y == '1) && (x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)))
      r = o[1] ? 64'd0 : x;
    else if (sgn) r = o[1] ? 64'($signed(x) % $signed(y)) : 64'($signed(x) / $signed(y));
    else r = o[1] ? (x % y) : (x / y);
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input string name);
    op = o;
    word = w;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    exp_q.push_back(e);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_cycle0 got=%b want=1", name, busy);
    end
  endtask

  task automatic wait_result(input int lat, input string name);
    int cyc;
    int bad;
    logic [63:0] e;
    cyc = 0;
    bad = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (valid !== 1'b1 && busy !== 1'b1) bad++;
    end while (valid !== 1'b1 && cyc < lat + 10);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout valid=%b after %0d cycles want valid at %0d", name, valid, cyc, lat);
    end else begin
      checks++;
      if (cyc !== lat) begin
        failures++;
        $display("FAIL %s latency got=%0d want=%0d", name, cyc, lat);
      end
      checks++;
      if (result !== e) begin
        failures++;
        $display("FAIL %s result got=%h want=%h", name, result, e);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_done got=%b want=0", name, busy);
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL %s busy_profile low_cycles=%0d want=0", name, bad);
      end
      last_exp = e;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] e, input int lat, input string name);
    @(negedge clk);
    #1;
    issue(o, w, a, b, e, name);
    wait_result(lat, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = DIV;
    word = 1'b0;
    rs1 = 64'd0;
    rs2 = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_signed();
    run(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 67, "div_m20_3");
    @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b want=0", valid); end
    checks++;
    if (result !== last_exp) begin
      failures++;
      $display("FAIL result_hold got=%h want=%h", result, last_exp);
    end
    issue(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, "rem_m20_3");
    wait_result(67, "rem_m20_3");
  endtask

  task automatic test_back_to_back();
    run(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 67, "remu_100_7");
    issue(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, "b2b_divu_100_7");
    wait_result(67, "b2b_divu_100_7");
  endtask

  task automatic test_div_zero();
    run(DIVU, 1'b0, 64'd5, 64'd0, '1, 2, "divu_by0");
    run(REM, 1'b0, 64'd5, 64'd0, 64'd5, 2, "rem_by0");
    run(DIV, 1'b1, 64'h1_8000_0000, 64'd0, '1, 2, "divw_by0");
  endtask

  task automatic test_overflow();
    run(DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, "div_ovf");
    run(REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, "rem_ovf");
    run(DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, "divw_ovf");
  endtask

  task automatic test_word();
    run(DIVU, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 35, "divuw_16_3");
    run(REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 35, "remw_m7_2");
    run(DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 35, "divuw_sext");
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    @(negedge clk);
    #1;
    start = 1'b1;
    op = DIVU;
    word = 1'b0;
    rs1 = 64'd1000;
    rs2 = 64'd7;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (valid === 1'b1) seen++;
      if (c == 20) flush = 1'b1;
    end
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b want=0", busy); end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_valid pulses=%0d want=0", seen); end
    checks++;
    if (result !== last_exp) begin
      failures++;
      $display("FAIL flush_result got=%h want=%h", result, last_exp);
    end
    issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, "after_flush");
    wait_result(67, "after_flush");
  endtask

  task automatic test_ignored_start();
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    #1;
    issue(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, "ignored_start");
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) begin
        start = 1'b1;
        op = DIV;
        rs1 = 64'd55;
        rs2 = 64'd5;
      end
      if (cyc == 11) start = 1'b0;
    end while (valid !== 1'b1 && cyc < 90);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    checks++;
    if (cyc !== 67) begin failures++; $display("FAIL ignored_start latency got=%0d want=67", cyc); end
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL ignored_start result got=%h want=%h", result, e);
    end
    last_exp = e;
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 62);
      b[0] = 1'b1;
      run(o, w, a, b, model(o, w, a, b), w ? 35 : 67, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #1;
    start = 1'b1;
    op = DIVU;
    word = 1'b0;
    rs1 = 64'd1000;
    rs2 = 64'd3;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL midrst_result got=%h want=0", result); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    rst = 1'b0;
    last_exp = 64'd0;
    run(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67, "after_reset");
  endtask

  initial begin
    test_reset();
    test_signed();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_word();
    test_flush();
    test_ignored_start();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
